// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared state encoding and line constants for serial_tx
package serial_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam int   DATA_BITS = 8;
   localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_tx_baud_tick.sv
// rtl/serial_tx_baud_tick.sv - bit-period counter, ticks on the last cycle of each period
module baud_tick #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int           W    = $clog2(CLKS_PER_BIT);
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

   logic [W-1:0] cnt;

   assign tick = (cnt == LAST);

   // count 0..CLKS_PER_BIT-1; clear realigns the period to a state entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clear || tick)
         cnt <= '0;
      else
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - byte-to-serial frame transmitter; SERIAL_TX_PARITY_EN adds an even parity bit
module serial_tx
   import serial_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] datain,
   input  logic       dvalid,
   output logic       ack,
   output logic       txd,
   output logic       busy,
   output logic       tfin,
   output logic [7:0] framecount
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   tx_state_t  state, state_d;
   logic [7:0] shift, shift_d;
   logic [2:0] bitidx, bitidx_d;
   logic       txd_d, ack_d, tfin_d;
   logic       tick, clear;
`ifdef SERIAL_TX_PARITY_EN
   logic       par;
`endif

   // the bit period restarts whenever the FSM changes state
   assign clear = (state_d != state);
   assign busy  = (state != IDLE);

   baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .tick  (tick)
   );

   // next-state, shift/bit-index update and the line level for the next cycle
   always_comb begin
      state_d  = state;
      shift_d  = shift;
      bitidx_d = bitidx;
      ack_d    = 1'b0;
      tfin_d   = 1'b0;
      txd_d    = LINE_IDLE;
      case (state)
         IDLE: begin
            if (dvalid) begin
               state_d = START;
               shift_d = datain;
               ack_d   = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               state_d  = DATA;
               bitidx_d = '0;
            end
         end
         DATA: begin
            if (tick) begin
               if (bitidx == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  shift_d  = shift >> 1;
                  bitidx_d = bitidx + 3'd1;
               end
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: begin
            if (tick)
               state_d = STOP;
         end
`endif
         STOP: begin
            if (tick) begin
               state_d = IDLE;
               tfin_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // txd is registered, so it is derived from where the FSM is going
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
         PARITY:  txd_d = par;
`endif
         default: txd_d = LINE_IDLE;
      endcase
   end

   // state, datapath and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         shift      <= '0;
         bitidx     <= '0;
         txd        <= LINE_IDLE;
         ack        <= 1'b0;
         tfin       <= 1'b0;
         framecount <= '0;
      end else begin
         state  <= state_d;
         shift  <= shift_d;
         bitidx <= bitidx_d;
         txd    <= txd_d;
         ack    <= ack_d;
         tfin   <= tfin_d;
         if (tfin_d)
            framecount <= framecount + 8'd1;
      end
   end

`ifdef SERIAL_TX_PARITY_EN
   // even parity of the whole byte, taken at capture before shifting starts
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         par <= 1'b0;
      else if (state == IDLE && dvalid)
         par <= ^datain;
   end
`endif

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - self-checking bench for serial_tx
module tb_serial_tx;

   localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] datain = 8'h00;
   logic       dvalid = 1'b0;
   logic       ack, txd, busy, tfin;
   logic [7:0] framecount;

   int n_cmp = 0;
   int n_err = 0;
   int exp_fc = 0;
   int cyc = 0;

   serial_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .reset      (reset),
      .datain     (datain),
      .dvalid     (dvalid),
      .ack        (ack),
      .txd        (txd),
      .busy       (busy),
      .tfin       (tfin),
      .framecount (framecount)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] b);
      logic [NBITS-1:0] fb;
      fb = '0;
      fb[0] = 1'b0;
      for (int k = 0; k < 8; k++) fb[k+1] = b[k];
`ifdef SERIAL_TX_PARITY_EN
      fb[9] = ^b;
`endif
      fb[NBITS-1] = 1'b1;
      return fb;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_txd"}, txd, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_ack"}, ack, 0);
      check({tag, "_tfin"}, tfin, 0);
   endtask

   task automatic send(input logic [7:0] b, input bit hold, output int ack_cyc);
      logic [NBITS-1:0] fb;
      logic [7:0]       dec;
      bit               got;
      fb = frame_bits(b);
      dec = 8'h00;
      ack_cyc = -1;
      datain = b;
      dvalid = 1'b1;
      got = 1'b0;
      for (int w = 0; w < 8 && !got; w++) begin
         @(negedge clk);
         got = (ack === 1'b1);
      end
      check("ack_seen", got, 1);
      if (!got) return;
      ack_cyc = cyc;
      for (int i = 0; i < NBITS*CPB; i++) begin
         check("txd", txd, fb[i/CPB]);
         check("busy", busy, 1);
         check("ack_pulse", ack, (i == 0));
         check("tfin_low", tfin, 0);
         if ((i % CPB) == CPB/2 && (i/CPB) >= 1 && (i/CPB) <= 8)
            dec[i/CPB-1] = txd;
         if (!hold) dvalid = 1'b0;
         datain = 8'($urandom);
         @(negedge clk);
      end
      exp_fc = (exp_fc + 1) % 256;
      check("tfin", tfin, 1);
      check("busy_gap", busy, 0);
      check("framecount", framecount, exp_fc);
      check("decoded", dec, b);
   endtask

   initial begin
      int a1, a2, a3;
      bit got;
      logic [7:0] b;

      repeat (3) @(negedge clk);
      check_idle("in_reset");
      check("in_reset_fc", framecount, 0);
      reset = 1'b0;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_idle("idle");
         check("idle_fc", framecount, 0);
      end

      send(8'hA5, 1'b0, a1);
      repeat (3) begin
         @(negedge clk);
         check_idle("after_a5");
      end

      send(8'h01, 1'b1, a1);
      send(8'h80, 1'b1, a2);
      send(8'hFF, 1'b0, a3);
      check("ack_gap1", a2 - a1, NBITS*CPB + 1);
      check("ack_gap2", a3 - a2, NBITS*CPB + 1);
      check("fc_after3", framecount, 4);

      for (int k = 0; k < 6; k++)
         send(8'($urandom), (k < 5), a1);

      b = 8'($urandom) & 8'hFB;
      datain = b;
      dvalid = 1'b1;
      got = 1'b0;
      for (int w = 0; w < 8 && !got; w++) begin
         @(negedge clk);
         got = (ack === 1'b1);
      end
      check("abort_ack_seen", got, 1);
      dvalid = 1'b0;
      repeat (15) @(negedge clk);
      check("abort_txd_before", txd, 0);
      reset = 1'b1;
      #1;
      check("abort_txd", txd, 1);
      check("abort_busy", busy, 0);
      check("abort_fc", framecount, 0);
      @(negedge clk);
      reset = 1'b0;
      exp_fc = 0;
      for (int i = 0; i < 2*NBITS*CPB; i++) begin
         @(negedge clk);
         check_idle("post_abort");
      end

      send(8'($urandom), 1'b0, a1);
      while (exp_fc != 255)
         send(8'($urandom), 1'($urandom_range(0, 1)), a1);
      check("fc_255", framecount, 255);
      send(8'($urandom), 1'b0, a1);
      check("fc_wrap", framecount, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_tx.md
# serial_tx

Byte-to-serial line transmitter sitting directly downstream of the transmit byte buffer. Pops one byte at a time from the buffer head via a valid/ack handshake and shifts it out as an asynchronous serial frame: start bit, 8 data bits LSB first, optional parity, stop bit. Pulses `tfin` at the end of each frame so the buffer side can track completion.

## Interface
- `CLKS_PER_BIT`, default 16: bit period in `clk` cycles; legal range ≥2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `datain`  in  8  byte at the buffer head; sampled only on the capture edge.
- `dvalid`  in  1  buffer holds ≥1 byte; ignored outside IDLE.
- `ack`  out  1  one-cycle pop pulse; upstream drops the head byte on it.
- `txd`  out  1  serial line, registered, idles high.
- `busy`  out  1  high in every state except IDLE.
- `tfin`  out  1  one-cycle pulse after the last stop-bit cycle.
- `framecount`  out  8  frames completed since reset; wraps 255→0.

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: `txd`=1. On an edge with `dvalid`=1:
  - capture `datain` into the shift register;
  - go to START;
  - `ack`=1 for exactly the following cycle.
- START: `txd`=0 for `CLKS_PER_BIT` cycles → DATA.
- DATA: `txd`=shift[0], held for `CLKS_PER_BIT` cycles, then shift right. After 8 bits → PARITY or STOP.
- PARITY: `txd`=even parity (XOR of the 8 captured bits) for `CLKS_PER_BIT` cycles → STOP.
- STOP: `txd`=1 for `CLKS_PER_BIT` cycles → IDLE. On that transition, `tfin`=1 for one cycle and `framecount`+1.
- Counters:
  - baud counter is `$clog2(CLKS_PER_BIT)` bits, counts 0..`CLKS_PER_BIT`-1 and clears on every state change;
  - bit index is 3 bits, 0..7;
  - `framecount` is modulo 256.
- Upstream must present the next byte (or drop `dvalid`) by the cycle after `ack`. `dvalid` held high gives back-to-back frames.
- `datain` changes outside the capture edge have no effect.

## Timing
- Reset values: `txd`=1, `ack`=0, `busy`=0, `tfin`=0, `framecount`=0; state IDLE; counters 0.
- Frame length: capture at edge k gives `txd` low from k+1. The frame occupies 10·`CLKS_PER_BIT` cycles, or 11·`CLKS_PER_BIT` with parity.
- `tfin` is high during the first IDLE cycle after the frame.
- Gap between frames is exactly 1 IDLE cycle, even when `dvalid` is continuously high.
- `ack` coincides with the first START cycle; `busy` rises on the same cycle.
- Reset mid-frame:
  - `txd` goes to 1 immediately (asynchronous);
  - the frame is aborted with no `tfin`;
  - the captured byte is lost (it was already acked);
  - `framecount` clears to 0.
- `tfin` and a new capture can occur on the same cycle: IDLE with `dvalid`=1 captures the next byte while `tfin` is high.

## Configuration
- `SERIAL_TX_PARITY_EN` defined: the PARITY state exists, with an even parity bit between data and stop; frame = 11 bits.
- Undefined: no PARITY state; DATA goes directly to STOP; frame = 10 bits.
- Handshake, `tfin` and `framecount` behaviour are identical in both builds.

## Structure
- Package `serial_tx_pkg` holds:
  - state enum typedef `tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - constants `DATA_BITS`=8 and `LINE_IDLE`=1'b1.
- Sub-module `baud_tick`: parameterised by `CLKS_PER_BIT`. Takes `clk`, `reset` and a synchronous `clear`, and outputs `tick` on the last cycle of each bit period. The FSM asserts `clear` on every state change.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Reset, `dvalid`=0 for 20 cycles → `txd`=1, `busy`=0, `ack`=0, `tfin`=0, `framecount`=0 throughout.
- One byte 8'hA5, parity off → one `ack` pulse. `txd` levels per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1. `tfin` 40 cycles after capture; `framecount`=1.
- Three bytes 8'h01, 8'h80, 8'hFF with `dvalid` held high → 3 `ack` pulses exactly 41 cycles apart, decoded bytes match, `framecount`=3.
- `SERIAL_TX_PARITY_EN` defined, byte 8'h07 → parity bit 1. Byte 8'h03 → parity bit 0. Each frame is 44 cycles.
- Reset asserted 15 cycles into a frame → `txd`=1 in the same cycle, `busy`=0, no `tfin`, `framecount`=0. The next byte after release transmits correctly.
- 256 consecutive frames → `framecount` reads 255 after frame 255, then wraps to 0 on frame 256.
